// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO pad controller.
package gpio_pkg;

    localparam logic PUSH_PULL         = 1'b0;
    localparam logic OPEN_DRAIN        = 1'b1;
    localparam int   DEBOUNCE_10MS_50M = 500000;

    // Open-drain only ever pulls low: the pad is released whenever the wanted value is 1.
    function automatic logic drive_oe(input logic mode, input logic oe, input logic value);
        return (mode == OPEN_DRAIN) ? (oe & ~value) : oe;
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// Signal bundle between the SoC GPIO block / pads (master) and gpio_pad_ctrl (slave).
interface gpio_pad_ctrl_if #(
    parameter int NUM_PINS = 8,
    parameter int PWM_BITS = 8
);
    logic [NUM_PINS-1:0]          out_i;
    logic [NUM_PINS-1:0]          oe_i;
    logic [NUM_PINS-1:0]          od_i;
    logic [NUM_PINS-1:0]          pad_i;
    logic [NUM_PINS-1:0]          pad_o;
    logic [NUM_PINS-1:0]          pad_oe;
    logic [NUM_PINS-1:0]          in_o;
    logic [NUM_PINS-1:0]          rise_o;
    logic [NUM_PINS-1:0]          fall_o;
    logic [NUM_PINS-1:0]          pending_o;
    logic [NUM_PINS-1:0]          irq_clr_i;
    logic [NUM_PINS-1:0]          irq_mask_i;
    logic                         irq_o;
    logic [NUM_PINS-1:0]          pwm_en_i;
    logic [NUM_PINS*PWM_BITS-1:0] pwm_duty_i;

    modport master (
        output out_i, oe_i, od_i, pad_i, irq_clr_i, irq_mask_i, pwm_en_i, pwm_duty_i,
        input  pad_o, pad_oe, in_o, rise_o, fall_o, pending_o, irq_o
    );

    modport slave (
        input  out_i, oe_i, od_i, pad_i, irq_clr_i, irq_mask_i, pwm_en_i, pwm_duty_i,
        output pad_o, pad_oe, in_o, rise_o, fall_o, pending_o, irq_o
    );
endinterface

// File: rtl/gpio_in_filter.sv
// Per-pin input path: synchroniser, optional debounce and registered rise/fall detect.
module gpio_in_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit DB_EN           = 1'b0
) (
    input  logic clk50,
    input  logic rst,
    input  logic pad,
    input  logic prime_load,
    input  logic primed,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync;
    logic                   stable_reg;
    logic                   prev_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   accept;

    assign sync = sync_reg[SYNC_STAGES-1];

    generate
        if (DB_EN) begin : g_db
            localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt_reg;

            // Any return to the accepted level restarts the stability window.
            always_ff @(posedge clk50 or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (!primed || sync == stable_reg || cnt_reg == CNT_MAX)
                    cnt_reg <= '0;
                else
                    cnt_reg <= cnt_reg + 1'b1;
            end

            assign accept = primed && (sync != stable_reg) && (cnt_reg == CNT_MAX);
        end else begin : g_nodb
            assign accept = primed;
        end
    endgenerate

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            sync_reg   <= '0;
            stable_reg <= 1'b0;
            prev_reg   <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad};
            // Priming seeds both stable and prev so the power-up level never looks like an edge.
            if (prime_load) begin
                stable_reg <= sync;
                prev_reg   <= sync;
            end else begin
                if (accept)
                    stable_reg <= sync;
                prev_reg <= stable_reg;
            end
            rise_reg <= primed & stable_reg & ~prev_reg;
            fall_reg <= primed & ~stable_reg & prev_reg;
        end
    end

    assign level = stable_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: pad drive, filtered inputs, sticky pending flags and IRQ.
// Optional per-pin PWM output when GPIO_PWM_EN is defined.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int                     NUM_PINS        = 8,
    parameter int                     SYNC_STAGES     = 2,
    parameter int                     DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
    parameter logic [NUM_PINS-1:0]    DB_MASK         = 8'h02,
    parameter int                     PWM_BITS        = 8
) (
    input  logic            clk50,
    input  logic            rst,
    gpio_pad_ctrl_if.slave  bus
);
    localparam int PW = $clog2(SYNC_STAGES + 1) + 1;

    logic [PW-1:0]       prime_cnt_reg;
    logic                primed_reg;
    logic                prime_load;
    logic [NUM_PINS-1:0] eff_out;
    logic [NUM_PINS-1:0] pad_o_next, pad_oe_next;
    logic [NUM_PINS-1:0] pad_o_reg, pad_oe_reg;
    logic [NUM_PINS-1:0] level, rise, fall;
    logic [NUM_PINS-1:0] pending_reg;
    logic                irq_reg;

    // Inputs are trusted once the synchroniser has flushed its reset contents.
    assign prime_load = ~primed_reg && (prime_cnt_reg == PW'(SYNC_STAGES));

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            prime_cnt_reg <= '0;
            primed_reg    <= 1'b0;
        end else if (!primed_reg) begin
            prime_cnt_reg <= prime_cnt_reg + 1'b1;
            if (prime_load)
                primed_reg <= 1'b1;
        end
    end

`ifdef GPIO_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_reg;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst)
            pwm_cnt_reg <= '0;
        else
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pwm
        assign eff_out[gi] = bus.pwm_en_i[gi]
                           ? (pwm_cnt_reg < bus.pwm_duty_i[gi*PWM_BITS +: PWM_BITS])
                           : bus.out_i[gi];
    end
`else
    assign eff_out = bus.out_i;
`endif

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        assign pad_o_next[gi]  = (bus.od_i[gi] == OPEN_DRAIN) ? 1'b0 : eff_out[gi];
        assign pad_oe_next[gi] = drive_oe(bus.od_i[gi], bus.oe_i[gi], eff_out[gi]);

        gpio_in_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_EN           (DB_MASK[gi])
        ) u_filter (
            .clk50      (clk50),
            .rst        (rst),
            .pad        (bus.pad_i[gi]),
            .prime_load (prime_load),
            .primed     (primed_reg),
            .level      (level[gi]),
            .rise       (rise[gi]),
            .fall       (fall[gi])
        );
    end

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            pad_o_reg   <= '0;
            pad_oe_reg  <= '0;
            pending_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            pad_o_reg   <= pad_o_next;
            pad_oe_reg  <= pad_oe_next;
            pending_reg <= (pending_reg & ~bus.irq_clr_i) | rise | fall;
            irq_reg     <= |(pending_reg & bus.irq_mask_i);
        end
    end

    assign bus.pad_o     = pad_o_reg;
    assign bus.pad_oe    = pad_oe_reg;
    assign bus.in_o      = level;
    assign bus.rise_o    = rise;
    assign bus.fall_o    = fall;
    assign bus.pending_o = pending_reg;
    assign bus.irq_o     = irq_reg;
endmodule
